// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM feeding decode.
// Define FETCH_TIMEOUT_EN to add the REQ-state wait timeout and fetch_err.
module fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter logic [3:0]  HALT_OP        = 4'hF,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc_next,
    output logic [15:0] pc_cur,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        flush,
    input  logic [15:0] flush_pc,
    output logic        halted,
    output logic [15:0] fetch_count,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_HALT
    } state_t;

    state_t state;

    assign imem_addr = pc_cur;

`ifdef FETCH_TIMEOUT_EN
    logic [15:0] tcnt;
`else
    // TIMEOUT_CYCLES only matters when the timeout is built in
    assign fetch_err = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc_cur      <= RESET_PC;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 16'h0000;
`ifdef FETCH_TIMEOUT_EN
            fetch_err   <= 1'b0;
            tcnt        <= 16'h0000;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush) pc_cur <= flush_pc;
                    imem_req <= 1'b1;
                    state    <= S_REQ;
                end
                S_REQ: begin
                    if (flush) begin
                        pc_cur <= flush_pc;
`ifdef FETCH_TIMEOUT_EN
                        tcnt   <= 16'h0000;
`endif
                    end else if (imem_ack) begin
                        instr       <= imem_data;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_HOLD;
`ifdef FETCH_TIMEOUT_EN
                        tcnt        <= 16'h0000;
`endif
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        fetch_err <= 1'b1;
                        halted    <= 1'b1;
                        imem_req  <= 1'b0;
                        tcnt      <= 16'h0000;
                        state     <= S_HALT;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
`endif
                end
                S_HOLD: begin
                    if (flush) begin
                        pc_cur      <= flush_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= S_REQ;
                    end else if (instr_ready) begin
                        pc_cur      <= pc_next;
                        fetch_count <= fetch_count + 16'd1;
                        instr_valid <= 1'b0;
                        if (instr[15:12] == HALT_OP) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against
// a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_next;
    logic [15:0] pc_cur;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic [15:0] flush_pc;
    logic        halted;
    logic [15:0] fetch_count;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC      (16'h0000),
        .HALT_OP       (4'hF),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_next    (pc_next),
        .pc_cur     (pc_cur),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .halted     (halted),
        .fetch_count(fetch_count),
        .fetch_err  (fetch_err)
    );

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Behavioural model: phase of the fetch and the architectural values
    typedef enum int {P_IDLE, P_REQ, P_HOLD, P_HALT} phase_t;
    phase_t      m_ph;
    logic [15:0] m_pc, m_instr, m_cnt;
    logic        m_err;
    int          m_wait;
    bit          timeout_on;

    initial begin
`ifdef FETCH_TIMEOUT_EN
        timeout_on = 1'b1;
`else
        timeout_on = 1'b0;
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph   <= P_IDLE;
            m_pc   <= 16'h0000;
            m_instr<= 16'h0000;
            m_cnt  <= 16'h0000;
            m_err  <= 1'b0;
            m_wait <= 0;
        end else begin
            case (m_ph)
                P_IDLE: begin
                    if (flush) m_pc <= flush_pc;
                    m_ph <= P_REQ;
                end
                P_REQ: begin
                    if (flush) begin
                        m_pc   <= flush_pc;
                        m_wait <= 0;
                    end else if (imem_ack) begin
                        m_instr <= imem_data;
                        m_ph    <= P_HOLD;
                        m_wait  <= 0;
                    end else if (timeout_on && m_wait + 1 >= TO) begin
                        m_err  <= 1'b1;
                        m_ph   <= P_HALT;
                        m_wait <= 0;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
                P_HOLD: begin
                    if (flush) begin
                        m_pc <= flush_pc;
                        m_ph <= P_REQ;
                    end else if (instr_ready) begin
                        m_pc  <= pc_next;
                        m_cnt <= m_cnt + 16'd1;
                        m_ph  <= (m_instr[15:12] == 4'hF) ? P_HALT : P_REQ;
                    end
                end
                default: m_ph <= P_HALT;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_cur", pc_cur, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("imem_req", 16'(imem_req), 16'(m_ph == P_REQ));
            chk("instr_valid", 16'(instr_valid), 16'(m_ph == P_HOLD));
            chk("halted", 16'(halted), 16'(m_ph == P_HALT));
            chk("instr", instr, m_instr);
            chk("fetch_count", fetch_count, m_cnt);
            chk("fetch_err", 16'(fetch_err), 16'(m_err));
        end
    end

    initial begin
        logic [15:0] exp_addr [3];
        int k;
        exp_addr[0] = 16'h0000;
        exp_addr[1] = 16'h0002;
        exp_addr[2] = 16'h0004;

        rst_n = 1'b0;
        pc_next = 16'h0000;
        imem_ack = 1'b0;
        imem_data = 16'h0000;
        instr_ready = 1'b0;
        flush = 1'b0;
        flush_pc = 16'h0000;

        repeat (2) @(negedge clk);
        chk("rst pc_cur", pc_cur, 16'h0000);
        chk("rst imem_req", 16'(imem_req), 16'h0);
        chk("rst instr", instr, 16'h0000);
        chk("rst fetch_count", fetch_count, 16'h0000);
        chk("rst fetch_err", 16'(fetch_err), 16'h0);
        chk_en = 1'b1;

        // Streaming fetch with immediate ack and pc+2
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_data = 16'h1234;
        instr_ready = 1'b1;
        pc_next = 16'h0002;
        k = 0;
        repeat (7) begin
            @(negedge clk);
            if (imem_req) begin
                if (k < 3) chk("seq addr", imem_addr, exp_addr[k]);
                k++;
            end
            pc_next = m_pc + 16'd2;
        end
        chk("seq count", fetch_count, 16'd3);
        imem_ack = 1'b0;
        instr_ready = 1'b0;

        // Decode stall: held instruction and PC stay put
        @(negedge clk);
        imem_ack = 1'b1;
        imem_data = 16'h5A5A;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (5) begin
            pc_next = 16'($urandom);
            @(negedge clk);
            chk("stall instr", instr, 16'h5A5A);
            chk("stall pc", pc_cur, 16'h0006);
            chk("stall valid", 16'(instr_valid), 16'h1);
        end
        instr_ready = 1'b1;
        pc_next = 16'h0040;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("stall release pc", pc_cur, 16'h0040);
        chk("stall release cnt", fetch_count, 16'd4);

        // Flush beats a same-cycle ack
        flush = 1'b1;
        flush_pc = 16'h0100;
        imem_ack = 1'b1;
        imem_data = 16'h1111;
        @(negedge clk);
        flush = 1'b0;
        imem_ack = 1'b0;
        chk("flush addr", imem_addr, 16'h0100);
        chk("flush cnt", fetch_count, 16'd4);
        chk("flush instr kept", instr, 16'h5A5A);
        chk("flush req", 16'(imem_req), 16'h1);

        // No ack: timeout boundary
        repeat (TO - 1) @(negedge clk);
        chk("to before", 16'(halted), 16'h0);
        @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        chk("to halted", 16'(halted), 16'h1);
        chk("to err", 16'(fetch_err), 16'h1);
`else
        chk("no-to req", 16'(imem_req), 16'h1);
        chk("no-to err", 16'(fetch_err), 16'h0);
`endif

        // Asynchronous reset in the middle of a cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst req", 16'(imem_req), 16'h0);
        chk("arst pc", pc_cur, 16'h0000);
        chk("arst halted", 16'(halted), 16'h0);
        chk("arst err", 16'(fetch_err), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst resume addr", imem_addr, 16'h0000);
        chk("arst resume req", 16'(imem_req), 16'h1);

        // Halt opcode stops fetch; flush ignored afterwards
        imem_ack = 1'b1;
        imem_data = 16'hF000;
        instr_ready = 1'b1;
        pc_next = 16'h0022;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("halt halted", 16'(halted), 16'h1);
        chk("halt req", 16'(imem_req), 16'h0);
        chk("halt pc", pc_cur, 16'h0022);
        chk("halt cnt", fetch_count, 16'd1);
        flush = 1'b1;
        flush_pc = 16'h0300;
        imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("halt flush pc", pc_cur, 16'h0022);
        chk("halt flush halted", 16'(halted), 16'h1);
        chk("halt flush req", 16'(imem_req), 16'h0);
        flush = 1'b0;
        imem_ack = 1'b0;

        // Randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            if (!rst_n) rst_n = 1'b1;
            imem_ack = ($urandom_range(0, 99) < 55);
            imem_data = 16'($urandom);
            if (imem_data[15:12] == 4'hF && $urandom_range(0, 3) != 0)
                imem_data[15:12] = 4'hE;
            instr_ready = ($urandom_range(0, 99) < 60);
            pc_next = 16'($urandom);
            flush = ($urandom_range(0, 99) < 6);
            flush_pc = 16'($urandom);
            if ($urandom_range(0, 79) == 0) begin
                #2 rst_n = 1'b0;
            end
            @(negedge clk);
        end

        rst_n = 1'b1;
        flush = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
